// File: rtl/fifo_block_packer.sv
// Packs bytes popped from the receive FIFO into BLOCKBYTES-wide AES plaintext blocks and pads the last block on flush.
// Build option PACKER_PKCS7_PAD_EN: PKCS#7 padding (empty flush emits a full pad block); undefined pads with 0x00.
module fifo_block_packer #(
    parameter int NUMBITS    = 8,
    parameter int BLOCKBYTES = 16,
    parameter int CNTBITS    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [NUMBITS-1:0]            fifo_r_data,
    output logic                          fifo_r_enable,
    input  logic                          flush,
    output logic [NUMBITS*BLOCKBYTES-1:0] blk_data,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic                          flush_done
);

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HOLD
    } state_t;

    localparam logic [CNTBITS-1:0] LAST_SLOT = CNTBITS'(BLOCKBYTES - 1);

    state_t             state;
    logic [CNTBITS-1:0] byte_cnt;
    logic               flush_pend;
    logic               padded;
    logic               last_slot;
    logic               slot_wr;
    logic [NUMBITS-1:0] slot_wr_data;
    logic [NUMBITS-1:0] pad_byte;
    logic [NUMBITS-1:0] slots [BLOCKBYTES];

`ifdef PACKER_PKCS7_PAD_EN
    localparam logic [NUMBITS-1:0] PAD_FULL = NUMBITS'(BLOCKBYTES);
    logic [NUMBITS-1:0] pad_val;

    assign pad_byte = pad_val;
`else
    assign pad_byte = '0;
`endif

    // The pop depends only on registered state and the FIFO flag, never on blk_ready.
    assign fifo_r_enable = (state == FILL) && !fifo_empty && !rst;
    assign last_slot     = (byte_cnt == LAST_SLOT);

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch can be inferred.
    always_comb begin
        slot_wr      = 1'b0;
        slot_wr_data = fifo_r_data;
        if (fifo_r_enable) begin
            slot_wr = 1'b1;
        end else if (state == PAD) begin
            slot_wr      = 1'b1;
            slot_wr_data = pad_byte;
        end
    end

    // NOTE: the slot array is reset, unlike a plain RAM, because blk_data must read zero out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCKBYTES; i++) begin
            if (rst) begin
                slots[i] <= '0;
            end else if (slot_wr && (byte_cnt == CNTBITS'(i))) begin
                slots[i] <= slot_wr_data;
            end
        end
    end

    // Byte 0 (first popped) lands in the most significant byte lane.
    always_comb begin
        blk_data = '0;
        for (int i = 0; i < BLOCKBYTES; i++) begin
            blk_data[(BLOCKBYTES-1-i)*NUMBITS +: NUMBITS] = slots[i];
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            byte_cnt   <= '0;
            flush_pend <= 1'b0;
            padded     <= 1'b0;
            blk_valid  <= 1'b0;
            flush_done <= 1'b0;
`ifdef PACKER_PKCS7_PAD_EN
            pad_val    <= '0;
`endif
        end else begin
            flush_done <= 1'b0;
            // A repeated flush is a no-op; the clears below only fire while flush_pend is already set.
            if (flush) begin
                flush_pend <= 1'b1;
            end

            case (state)
                FILL: begin
                    if (fifo_r_enable) begin
                        if (last_slot) begin
                            byte_cnt  <= '0;
                            state     <= HOLD;
                            blk_valid <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CNTBITS'(1);
                        end
                    end else if (flush_pend && fifo_empty) begin
                        if (byte_cnt != '0) begin
                            state <= PAD;
`ifdef PACKER_PKCS7_PAD_EN
                            pad_val <= NUMBITS'(BLOCKBYTES) - NUMBITS'(byte_cnt);
`endif
                        end else begin
`ifdef PACKER_PKCS7_PAD_EN
                            state   <= PAD;
                            pad_val <= PAD_FULL;
`else
                            flush_pend <= 1'b0;
                            flush_done <= 1'b1;
`endif
                        end
                    end
                end

                PAD: begin
                    if (last_slot) begin
                        byte_cnt  <= '0;
                        state     <= HOLD;
                        blk_valid <= 1'b1;
                        padded    <= 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + CNTBITS'(1);
                    end
                end

                HOLD: begin
                    if (blk_ready) begin
                        state     <= FILL;
                        blk_valid <= 1'b0;
                        if (padded) begin
                            padded     <= 1'b0;
                            flush_pend <= 1'b0;
                            flush_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= FILL;
                    blk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
